fir_filter_param: RTL and testbench

FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

---
 rtl/fir_filter_param.sv | 149 ++++++++++++++
 tb/tb_fir_filter_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_param.sv
// Purpose: serial multiply-accumulate FIR filter with run-time writable coefficients.
// Latency: out_valid rises in the cycle after the (TAPS+1)th edge following acceptance; one sample per TAPS+2 cycles.
// Backpressure: in_ready is high only in IDLE; in_valid outside IDLE is ignored. FIR_SAT_OUT_EN selects saturating output.
module fir_filter_param #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 8,
    parameter int OUT_SHIFT = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   data_in,
    output logic                       out_valid,
    output logic signed [DATA_W-1:0]   data_out,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata
);

    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    // Headroom of clog2(TAPS) bits lets TAPS full-scale products sum without wrap.
    localparam int ACC_W  = PROD_W + AW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [DATA_W-1:0]  r_tap  [TAPS];
    logic signed [COEF_W-1:0]  r_coef [TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic [AW-1:0]             r_cnt;
    logic                      r_out_valid;
    logic signed [DATA_W-1:0]  r_data_out;

    logic                      w_idle;
    logic                      w_run;
    logic                      w_done;
    logic                      w_accept;
    logic                      w_coef_wr;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_shift;
    logic signed [DATA_W-1:0]  w_out;

    // State register; reset aborts any computation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE -> RUN on a valid sample, RUN for TAPS edges, DONE for one edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)     w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == '0)  w_state_nxt = S_DONE;
            S_DONE:                    w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // State decode used by the datapath and the handshake.
    always_comb begin
        w_idle = (r_state == S_IDLE);
        w_run  = (r_state == S_RUN);
        w_done = (r_state == S_DONE);
    end

    assign in_ready  = w_idle;
    assign w_accept  = in_valid && w_idle;
    // Writes land only while idle; out-of-range addresses (non-power-of-two TAPS) are dropped.
    assign w_coef_wr = coef_we && w_idle && (32'(coef_addr) < TAPS);

    // Delay line shifts only on an accepted sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) r_tap[i] <= '0;
        end else if (w_accept) begin
            r_tap[0] <= data_in;
            for (int i = 1; i < TAPS; i++) r_tap[i] <= r_tap[i-1];
        end
    end

    // Coefficient bank; a write on the acceptance edge is visible to the RUN it starts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
        end else if (w_coef_wr) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    // Full-precision signed product of the tap currently addressed by the counter.
    assign w_prod     = PROD_W'(r_tap[r_cnt]) * PROD_W'(r_coef[r_cnt]);
    assign w_prod_ext = ACC_W'(w_prod);

    // Accumulator and tap counter: cleared on acceptance, walk TAPS-1 down to 0 in RUN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
            r_cnt <= AW'(TAPS - 1);
        end else if (w_run) begin
            r_acc <= r_acc + w_prod_ext;
            r_cnt <= r_cnt - AW'(1);
        end
    end

    assign w_shift = r_acc >>> OUT_SHIFT;

`ifdef FIR_SAT_OUT_EN
    logic [ACC_W-DATA_W:0] w_hi;
    // Clamp when the bits above the output sign bit are not a pure sign extension.
    always_comb begin
        w_hi  = w_shift[ACC_W-1:DATA_W-1];
        w_out = w_shift[DATA_W-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            w_out = w_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    // Truncating wrap: keep the low DATA_W bits of the shifted accumulator.
    assign w_out = w_shift[DATA_W-1:0];
`endif

    // Output register: one-cycle valid pulse, data held until the next result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_out_valid <= w_done;
            if (w_done) r_data_out <= w_out;
        end
    end

    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param: impulse, step, coefficient-write gating, reset abort,
// continuous in_valid, and accumulator overflow (second instance with OUT_SHIFT=0).
// Build with or without FIR_SAT_OUT_EN; overflow expectations follow the macro.
module tb_fir_filter_param;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] data_in;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [7:0]  coef_wdata;
    logic        in_ready, out_valid;
    logic [15:0] data_out;
    logic        ovf_in_ready, ovf_out_valid;
    logic [15:0] ovf_data_out;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    int t_acc = 0;

    logic [7:0]  coef_def [8] = '{8'd2, 8'd12, 8'd42, 8'd71, 8'd71, 8'd42, 8'd12, 8'd2};
    logic [15:0] imp_exp  [8] = '{16'd2, 16'd12, 16'd42, 16'd71, 16'd71, 16'd42, 16'd12, 16'd2};
    logic [15:0] step_exp [8] = '{16'd2, 16'd14, 16'd56, 16'd127, 16'd198, 16'd240, 16'd252, 16'd254};
    logic [15:0] fl_exp   [8] = '{16'd252, 16'd240, 16'd198, 16'd127, 16'd56, 16'd14, 16'd2, 16'd0};
    logic [15:0] q [$];

    always #5 clock = ~clock;

    fir_filter_param #(.DATA_W(16), .COEF_W(8), .TAPS(8), .OUT_SHIFT(8)) u_dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .data_out(data_out),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
    );

    fir_filter_param #(.DATA_W(16), .COEF_W(8), .TAPS(8), .OUT_SHIFT(0)) u_ovf (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ovf_in_ready),
        .data_in(data_in), .out_valid(ovf_out_valid), .data_out(ovf_data_out),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic load_coefs(input bit all127);
        for (int i = 0; i < 8; i++) begin
            coef_we    = 1'b1;
            coef_addr  = 3'(i);
            coef_wdata = all127 ? 8'd127 : coef_def[i];
            tick();
        end
        coef_we = 1'b0;
    endtask

    task automatic accept(input logic [15:0] s);
        data_in  = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        t_acc    = cyc;
    endtask

    task automatic wait_out(input string tag, input logic [15:0] exp, input bit chk_dat);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(cyc - t_acc), 32'd9);
        if (chk_dat) check({tag, "_dat"}, {16'h0, data_out}, {16'h0, exp});
    endtask

    task automatic run_sample(input string tag, input logic [15:0] s, input logic [15:0] exp);
        accept(s);
        wait_out(tag, exp, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_pulse;
        reset_n = 1'b0; in_valid = 1'b0; data_in = '0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        #12;
        check("rst_rdy", {31'h0, in_ready}, 32'd1);
        check("rst_vld", {31'h0, out_valid}, 32'd0);
        check("rst_dat", {16'h0, data_out}, 32'd0);
        reset_n = 1'b1;

        // Impulse, then step, then zero flush from an all-0x0100 delay line.
        load_coefs(1'b0);
        for (int i = 0; i < 8; i++)
            run_sample($sformatf("imp%0d", i), (i == 0) ? 16'h0100 : 16'h0000, imp_exp[i]);
        for (int i = 0; i < 8; i++)
            run_sample($sformatf("step%0d", i), 16'h0100, step_exp[i]);
        for (int i = 0; i < 8; i++)
            run_sample($sformatf("flush%0d", i), 16'h0000, fl_exp[i]);

        // Coefficient write during RUN must be dropped.
        accept(16'h0100);
        tick();
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 8'd100;
        tick();
        coef_we = 1'b0;
        wait_out("runwr", 16'd2, 1'b1);
        for (int i = 1; i < 8; i++)
            run_sample($sformatf("runwr_imp%0d", i), 16'h0000, imp_exp[i]);
        // Write coinciding with acceptance (IDLE) takes effect for that sample.
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 8'd100;
        accept(16'h0100);
        coef_we = 1'b0;
        wait_out("idlewr", 16'd100, 1'b1);

        // Reset asserted while RUN count is 3.
        accept(16'h0100);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("abort_rdy", {31'h0, in_ready}, 32'd1);
        check("abort_vld", {31'h0, out_valid}, 32'd0);
        check("abort_dat", {16'h0, data_out}, 32'd0);
        #1;
        reset_n = 1'b1;
        run_sample("post_rst_first", 16'h0000, 16'h0000);
        n_pulse = 0;
        repeat (10) begin
            tick();
            if (out_valid) n_pulse++;
        end
        check("abort_pulses", 32'(n_pulse), 32'd0);
        load_coefs(1'b0);
        for (int i = 0; i < 8; i++)
            run_sample($sformatf("rst_imp%0d", i), (i == 0) ? 16'h0100 : 16'h0000, imp_exp[i]);

        // in_valid held high: one acceptance every 10 cycles, junk in between never shifted.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        load_coefs(1'b0);
        for (int j = 0; j < 30; j++) begin
            check($sformatf("cont_rdy%0d", j), {31'h0, in_ready}, {31'h0, (j % 10 == 0)});
            in_valid = 1'b1;
            data_in  = (j % 10 == 0) ? 16'h0100 : 16'h7FFF;
            tick();
            if (out_valid) q.push_back(data_out);
        end
        in_valid = 1'b0;
        check("cont_nout", 32'(q.size()), 32'd3);
        if (q.size() == 3) begin
            check("cont_out0", {16'h0, q[0]}, 32'd2);
            check("cont_out1", {16'h0, q[1]}, 32'd14);
            check("cont_out2", {16'h0, q[2]}, 32'd56);
        end

        // Overflow: all coefficients 127, eight full-scale samples; acc = 8*127*32767.
        load_coefs(1'b1);
        for (int i = 0; i < 8; i++) begin
            accept(16'h7FFF);
            wait_out($sformatf("ovf%0d", i), 16'h0, 1'b0);
        end
        check("ovf_vld", {31'h0, ovf_out_valid}, 32'd1);
`ifdef FIR_SAT_OUT_EN
        check("ovf_sh0_dat", {16'h0, ovf_data_out}, 32'h7FFF);
        check("ovf_sh8_dat", {16'h0, data_out}, 32'h7FFF);
`else
        check("ovf_sh0_dat", {16'h0, ovf_data_out}, 32'hFC08);
        check("ovf_sh8_dat", {16'h0, data_out}, 32'hFBFC);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
